wb_commit_unit: RTL and testbench

Writeback/commit stage that consumes the outputs of the MEM/WB pipeline latch. It selects the writeback data, drives the register-file write port, and retires instructions. It also keeps a sticky system halt, a retired-instruction counter, and a one-entry last-write history that the forwarding unit uses to cover the register-file write/read window.

---
 rtl/wb_commit_unit.sv | 103 ++++++++++
 tb/tb_wb_commit_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: selects write data, drives the register-file port, retires and halts.
// Write port is combinational; retired/history/halt update one edge after commit; wb_en low holds all state.
module wb_commit_unit #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             wb_valid,
  input  logic             wb_en,
  input  logic             RegWr_o,
  input  logic [1:0]       MemToReg_o,
  input  logic [4:0]       wsel_o,
  input  logic [31:0]      OutputPort_o,
  input  logic [31:0]      dmemload_o,
  input  logic [31:0]      pc4_o,
  input  logic [31:0]      lui_imm_o,
  input  logic             halt_o,
  output logic             rf_WEN,
  output logic [4:0]       rf_wsel,
  output logic [31:0]      rf_wdat,
  output logic             halt,
  output logic [CNT_W-1:0] retired,
  output logic             fwd_valid,
  output logic [4:0]       fwd_sel,
  output logic [31:0]      fwd_dat
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             fwd_valid_q, fwd_valid_d;
  logic [4:0]       fwd_sel_q, fwd_sel_d;
  logic [31:0]      fwd_dat_q, fwd_dat_d;
  logic             commit;
  logic [31:0]      wdat;

  always_comb begin
    wdat = OutputPort_o;
    case (MemToReg_o)
      2'd0: wdat = OutputPort_o;
      2'd1: wdat = dmemload_o;
      2'd2: wdat = pc4_o;
      2'd3: wdat = lui_imm_o;
      default: wdat = OutputPort_o;
    endcase
  end

  assign commit  = wb_valid & wb_en & (state_q == RUN);
  // Gated by nRST so the register file never sees a write while reset is held.
  assign rf_WEN  = nRST & commit & RegWr_o & (wsel_o != 5'd0) & ~halt_o;
  assign rf_wsel = wsel_o;
  assign rf_wdat = wdat;

  always_comb begin
    state_d     = state_q;
    retired_d   = retired_q;
    fwd_valid_d = fwd_valid_q;
    fwd_sel_d   = fwd_sel_q;
    fwd_dat_d   = fwd_dat_q;
    case (state_q)
      RUN: begin
        if (commit) begin
          if (retired_q != {CNT_W{1'b1}}) retired_d = retired_q + 1'b1;
          if (halt_o) state_d = HALTED;
        end
        if (rf_WEN) begin
          fwd_valid_d = 1'b1;
          fwd_sel_d   = wsel_o;
          fwd_dat_d   = wdat;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      retired_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_sel_q   <= 5'd0;
      fwd_dat_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      retired_q   <= retired_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_sel_q   <= fwd_sel_d;
      fwd_dat_q   <= fwd_dat_d;
    end
  end

  assign halt      = (state_q == HALTED);
  assign retired   = retired_q;
  assign fwd_valid = fwd_valid_q;
  assign fwd_sel   = fwd_sel_q;
  assign fwd_dat   = fwd_dat_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit with a 4-bit retired counter so saturation is reachable.
module tb_wb_commit_unit;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             wb_valid, wb_en, RegWr_o, halt_o;
  logic [1:0]       MemToReg_o;
  logic [4:0]       wsel_o;
  logic [31:0]      OutputPort_o, dmemload_o, pc4_o, lui_imm_o;
  logic             rf_WEN;
  logic [4:0]       rf_wsel;
  logic [31:0]      rf_wdat;
  logic             halt;
  logic [CNT_W-1:0] retired;
  logic             fwd_valid;
  logic [4:0]       fwd_sel;
  logic [31:0]      fwd_dat;

  wb_commit_unit #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .wb_valid(wb_valid), .wb_en(wb_en),
    .RegWr_o(RegWr_o), .MemToReg_o(MemToReg_o), .wsel_o(wsel_o),
    .OutputPort_o(OutputPort_o), .dmemload_o(dmemload_o), .pc4_o(pc4_o),
    .lui_imm_o(lui_imm_o), .halt_o(halt_o), .rf_WEN(rf_WEN), .rf_wsel(rf_wsel),
    .rf_wdat(rf_wdat), .halt(halt), .retired(retired), .fwd_valid(fwd_valid),
    .fwd_sel(fwd_sel), .fwd_dat(fwd_dat)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: abstract machine state
  bit        m_halted;
  int        m_cnt;
  bit        m_fv;
  int        m_fsel;
  logic [31:0] m_fdat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sel_data(input logic [1:0] m);
    logic [31:0] cand [4];
    cand[0] = OutputPort_o; cand[1] = dmemload_o; cand[2] = pc4_o; cand[3] = lui_imm_o;
    return cand[m];
  endfunction

  task automatic model_reset();
    m_halted = 0; m_cnt = 0; m_fv = 0; m_fsel = 0; m_fdat = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".halt"}, 32'(halt), 32'(m_halted));
    chk({tag, ".retired"}, 32'(retired), m_cnt);
    chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(m_fv));
    chk({tag, ".fwd_sel"}, 32'(fwd_sel), m_fsel);
    chk({tag, ".fwd_dat"}, fwd_dat, m_fdat);
  endtask

  // One clock: comb checks before the edge, state checks after it.
  task automatic cycle(input string tag);
    bit committed, writes;
    logic [31:0] d;
    #1;
    committed = wb_valid && wb_en && !m_halted;
    writes    = committed && RegWr_o && (wsel_o != 0) && !halt_o;
    d         = sel_data(MemToReg_o);
    chk({tag, ".rf_WEN"}, 32'(rf_WEN), 32'(writes));
    chk({tag, ".rf_wsel"}, 32'(rf_wsel), 32'(wsel_o));
    chk({tag, ".rf_wdat"}, rf_wdat, d);
    @(posedge CLK);
    #1;
    if (committed) begin
      if (m_cnt < CMAX) m_cnt++;
      if (writes) begin m_fv = 1; m_fsel = wsel_o; m_fdat = d; end
      if (halt_o) m_halted = 1;
    end
    check_state(tag);
  endtask

  task automatic drive(input logic v, input logic en, input logic rw, input logic h,
                       input logic [1:0] m, input logic [4:0] ws);
    wb_valid = v; wb_en = en; RegWr_o = rw; halt_o = h; MemToReg_o = m; wsel_o = ws;
  endtask

  // Async reset asserted mid-cycle (called just after a rising edge).
  task automatic async_reset(input string tag);
    #2;
    nRST = 1'b0;
    #1;
    model_reset();
    check_state(tag);
    chk({tag, ".rf_WEN_in_reset"}, 32'(rf_WEN), 32'd0);
    #3;
    nRST = 1'b1;
  endtask

  typedef struct {
    logic v, en, rw, h;
    logic [1:0] m2r;
    logic [4:0] ws;
    logic ewen;
    logic [31:0] ewdat;
    int eret;
    logic [4:0] efsel;
    logic [31:0] efdat;
  } vec_t;

  vec_t tbl [10];

  initial begin
    nRST = 1'b0;
    drive(1, 1, 1, 0, 2'd0, 5'd5);
    OutputPort_o = 32'hA5A5_0000; dmemload_o = 32'h1111_2222;
    pc4_o = 32'h0000_0104; lui_imm_o = 32'hABCD_0000;
    model_reset();

    tbl[0] = '{1,1,1,0, 2'd0, 5'd5, 1, 32'hA5A5_0000, 1, 5'd5, 32'hA5A5_0000};
    tbl[1] = '{1,1,1,0, 2'd1, 5'd5, 1, 32'h1111_2222, 2, 5'd5, 32'h1111_2222};
    tbl[2] = '{1,1,1,0, 2'd2, 5'd5, 1, 32'h0000_0104, 3, 5'd5, 32'h0000_0104};
    tbl[3] = '{1,1,1,0, 2'd3, 5'd5, 1, 32'hABCD_0000, 4, 5'd5, 32'hABCD_0000};
    tbl[4] = '{1,1,1,0, 2'd2, 5'd0, 0, 32'h0000_0104, 5, 5'd5, 32'hABCD_0000};
    tbl[5] = '{1,0,1,0, 2'd1, 5'd7, 0, 32'h1111_2222, 5, 5'd5, 32'hABCD_0000};
    tbl[6] = '{1,0,1,0, 2'd1, 5'd7, 0, 32'h1111_2222, 5, 5'd5, 32'hABCD_0000};
    tbl[7] = '{1,0,1,0, 2'd1, 5'd7, 0, 32'h1111_2222, 5, 5'd5, 32'hABCD_0000};
    tbl[8] = '{1,1,1,0, 2'd1, 5'd7, 1, 32'h1111_2222, 6, 5'd7, 32'h1111_2222};
    tbl[9] = '{0,1,1,0, 2'd0, 5'd9, 0, 32'hA5A5_0000, 6, 5'd7, 32'h1111_2222};

    #2;
    check_state("reset");
    chk("reset.rf_WEN", 32'(rf_WEN), 32'd0);
    #10;
    nRST = 1'b1;

    // Commit to $0 first: history must stay invalid from reset
    drive(1, 1, 1, 0, 2'd0, 5'd0);
    cycle("r0_write");
    async_reset("rst0");

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].en, tbl[i].rw, tbl[i].h, tbl[i].m2r, tbl[i].ws);
      #1;
      chk($sformatf("tbl%0d.wen", i), 32'(rf_WEN), 32'(tbl[i].ewen));
      chk($sformatf("tbl%0d.wdat", i), rf_wdat, tbl[i].ewdat);
      @(posedge CLK);
      #1;
      chk($sformatf("tbl%0d.ret", i), 32'(retired), tbl[i].eret);
      chk($sformatf("tbl%0d.fsel", i), 32'(fwd_sel), 32'(tbl[i].efsel));
      chk($sformatf("tbl%0d.fdat", i), fwd_dat, tbl[i].efdat);
      chk($sformatf("tbl%0d.fv", i), 32'(fwd_valid), 32'd1);
      m_cnt = tbl[i].eret; m_fv = 1; m_fsel = tbl[i].efsel; m_fdat = tbl[i].efdat;
    end

    // HALT stalled first: no commit, then HALT with RegWr commits
    drive(1, 0, 1, 1, 2'd0, 5'd3);
    cycle("halt_stalled");
    drive(1, 1, 1, 1, 2'd0, 5'd3);
    cycle("halt_commit");
    chk("halt_set", 32'(halt), 32'd1);
    chk("halt_ret", 32'(retired), 32'd7);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 2'(i), 5'(10 + i));
      cycle("after_halt");
    end
    chk("halt_frozen_ret", 32'(retired), 32'd7);
    chk("halt_frozen_fsel", 32'(fwd_sel), 32'd7);

    // Reset while HALTED with a valid history entry, inputs still asserting a write
    drive(1, 1, 1, 0, 2'd3, 5'd4);
    async_reset("rst_halted");
    cycle("post_reset_write");
    chk("post_reset_fv", 32'(fwd_valid), 32'd1);
    chk("post_reset_ret", 32'(retired), 32'd1);

    // Saturation
    drive(1, 1, 1, 0, 2'd1, 5'd2);
    for (int i = 0; i < 18; i++) cycle("sat");
    chk("sat_hold", 32'(retired), 32'd15);

    // Randomized traffic, several reset-separated blocks
    for (int b = 0; b < 4; b++) begin
      async_reset("rnd_rst");
      for (int i = 0; i < 80; i++) begin
        wb_valid     = ($urandom_range(0, 3) != 0);
        wb_en        = ($urandom_range(0, 4) != 0);
        RegWr_o      = $urandom_range(0, 1);
        halt_o       = ($urandom_range(0, 39) == 0);
        MemToReg_o   = 2'($urandom_range(0, 3));
        wsel_o       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        OutputPort_o = $urandom; dmemload_o = $urandom;
        pc4_o        = $urandom; lui_imm_o  = $urandom;
        cycle("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
